mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
- Stateful arbiter sharing the single main-memory port between Dcache and Icache.
- Selects one requester per cycle. Dcache has priority; a starvation counter bounds how long the Icache can be blocked.
- Records which cache owns each outstanding load tag. Routes tagged data returns only to that owner.
- Sits between both caches and the memory model/bus.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive cycles the Icache may lose arbitration while requesting. 0 means strict Dcache priority.
- NUM_TAGS, 16: size of the memory tag space. Tag 0 means "no tag".

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Dcache2mem_command  in  BUS_COMMAND  Dcache request (BUS_NONE/BUS_LOAD/BUS_STORE)
- Dcache2mem_size  in  MEM_SIZE  Dcache access size
- Dcache2mem_addr  in  `XLEN  Dcache address
- Dcache2mem_data  in  2*`XLEN  Dcache store data
- Icache2mem_command  in  BUS_COMMAND  Icache request (loads only)
- Icache2mem_addr  in  `XLEN  Icache address
- mem2cache_response  in  4  tag returned by memory for this cycle's request; 0 = rejected
- mem2cache_data  in  64  returned data
- mem2cache_tag  in  4  tag of returned data; 0 = none
- cache2mem_command  out  BUS_COMMAND  selected command
- cache2mem_size  out  MEM_SIZE  selected size; DOUBLE when Icache is selected
- cache2mem_addr  out  `XLEN  selected address
- cache2mem_data  out  2*`XLEN  selected store data; 0 when Icache is selected
- mem2Dcache_response  out  4  mem2cache_response if Dcache selected, else 0
- mem2Icache_response  out  4  mem2cache_response if Icache selected, else 0
- mem2Dcache_data / mem2Icache_data  out  64  mem2cache_data (broadcast)
- mem2Dcache_tag / mem2Icache_tag  out  4  mem2cache_tag if routed to that cache, else 0
- mem2Dcache_data_valid / mem2Icache_data_valid  out  1  one-cycle pulse: data is for this cache

Behaviour:
- Selection is combinational from the current requests and registered state:
  - Icache selected if (Icache requests AND Dcache idle) OR (Icache requests AND starve_cnt == STARVE_LIMIT AND STARVE_LIMIT != 0).
  - Otherwise Dcache selected if it requests.
  - No request: cache2mem_command = BUS_NONE, addr/data = 0, size = DOUBLE.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - Increments when the Icache requests and the Dcache is selected.
  - Clears when the Icache is selected or the Icache is not requesting.
  - Saturates at STARVE_LIMIT.
  - "Selected" counts whether or not memory accepted the request (response 0 still counts).
- Owner table: NUM_TAGS entries, each {valid, owner}, owner 0 = D, 1 = I. Registered.
  - Allocate: selected command is BUS_LOAD and mem2cache_response != 0. Next cycle, entry[response] = {1, selected owner}.
  - Stores are never allocated.
- Routing, combinational from the current table:
  - If mem2cache_tag != 0 and entry[tag].valid, pulse data_valid to entry.owner and drive that cache's tag output. entry[tag].valid clears next cycle.
  - A return to an invalid entry, or tag 0, is dropped: both data_valid = 0, both tag outputs = 0.
- Same cycle, same tag returned and re-allocated: the allocation wins (valid = 1, new owner). The return is routed using the old owner.
- Entry 0 is never allocated or routed.
- Reset (asynchronous):
  - All valid bits = 0, starve_cnt = 0.
  - Combinational outputs follow the reset state: no routing, so data_valid = 0.
  - Loads outstanding across reset are forgotten; their later returns are dropped.
- Zero added latency on both the request and return paths. Table updates are visible the cycle after the triggering event.

Optional Feature:
- MEM_ARB_STATS_EN defined: adds 32-bit output counters d_grant_cnt, i_grant_cnt and drop_cnt, plus a 1-bit sticky output tag_error.
  - Grant counters increment on each accepted request (response != 0) for that cache.
  - drop_cnt increments on each dropped nonzero return tag.
  - tag_error sets when an allocation targets a tag that is already valid and no same-cycle return of that tag frees it.
  - All are cleared by reset.
- MEM_ARB_STATS_EN undefined: these ports and registers do not exist. Behaviour is otherwise identical.

Test Plan:
- Icache-only BUS_LOAD addr 0x100, response 3 -> cache2mem_size = DOUBLE, mem2Icache_response = 3, mem2Dcache_response = 0. Next cycle tag = 3, data = 0xDEAD -> mem2Icache_data_valid = 1, mem2Icache_tag = 3, Dcache valid = 0.
- STARVE_LIMIT = 4, both requesting continuously -> Dcache selected cycles 0–3, Icache selected cycle 4, Dcache selected cycles 5–8, Icache selected cycle 9.
- Dcache BUS_STORE accepted with response 5, later tag 5 returns -> both data_valid = 0 (no allocation for stores).
- Dcache load gets tag 1, Icache load gets tag 2; returns arrive in order 2 then 1 -> Icache pulse on tag 2, then Dcache pulse on tag 1.
- Icache load outstanding on tag 7, reset asserted mid-cycle, tag 7 then returns -> dropped; starve_cnt = 0.
- Tag 4 owned by D returns in the same cycle a new Icache load is accepted with response 4 -> Dcache receives the data; entry 4 is then valid with owner I; the following tag 4 return goes to the Icache.

Source files
------------

// File: rtl/mem_req_arbiter.sv
// Arbitrates the Dcache and Icache onto one memory port and routes tagged returns to their owner.
// Optional MEM_ARB_STATS_EN adds grant/drop counters and a sticky tag_error output.
`ifndef XLEN
`define XLEN 32
`endif

package mem_req_arbiter_pkg;
   typedef enum logic [1:0] {
      BUS_NONE  = 2'b00,
      BUS_LOAD  = 2'b01,
      BUS_STORE = 2'b10
   } bus_command_t;

   typedef enum logic [1:0] {
      BYTE   = 2'b00,
      HALF   = 2'b01,
      WORD   = 2'b10,
      DOUBLE = 2'b11
   } mem_size_t;
endpackage

module mem_req_arbiter
   import mem_req_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int NUM_TAGS     = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  bus_command_t          Dcache2mem_command,
   input  mem_size_t             Dcache2mem_size,
   input  logic [`XLEN-1:0]      Dcache2mem_addr,
   input  logic [2*`XLEN-1:0]    Dcache2mem_data,
   input  bus_command_t          Icache2mem_command,
   input  logic [`XLEN-1:0]      Icache2mem_addr,
   input  logic [3:0]            mem2cache_response,
   input  logic [63:0]           mem2cache_data,
   input  logic [3:0]            mem2cache_tag,
   output bus_command_t          cache2mem_command,
   output mem_size_t             cache2mem_size,
   output logic [`XLEN-1:0]      cache2mem_addr,
   output logic [2*`XLEN-1:0]    cache2mem_data,
   output logic [3:0]            mem2Dcache_response,
   output logic [3:0]            mem2Icache_response,
   output logic [63:0]           mem2Dcache_data,
   output logic [63:0]           mem2Icache_data,
   output logic [3:0]            mem2Dcache_tag,
   output logic [3:0]            mem2Icache_tag,
   output logic                  mem2Dcache_data_valid,
   output logic                  mem2Icache_data_valid
`ifdef MEM_ARB_STATS_EN
   ,
   output logic [31:0]           d_grant_cnt,
   output logic [31:0]           i_grant_cnt,
   output logic [31:0]           drop_cnt,
   output logic                  tag_error
`endif
);

   localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0]    starve_cnt_r;
   logic [NUM_TAGS-1:0] tag_valid_r;
   logic [NUM_TAGS-1:0] tag_owner_r;

   logic d_req_s;
   logic i_req_s;
   logic starve_hit_s;
   logic i_sel_s;
   logic d_sel_s;
   logic alloc_s;
   logic ret_hit_s;
   logic ret_owner_s;

   // Tag 0 means "no tag" and tags beyond the table are never tracked.
   function automatic logic tag_in_range(input logic [3:0] tag);
      return (tag != 4'd0) && (int'(tag) < NUM_TAGS);
   endfunction

   // Requester selection: Dcache first unless the Icache has waited STARVE_LIMIT cycles.
   always_comb begin
      d_req_s      = (Dcache2mem_command != BUS_NONE);
      i_req_s      = (Icache2mem_command != BUS_NONE);
      starve_hit_s = (STARVE_LIMIT != 0) && (starve_cnt_r == STARVE_MAX);
      i_sel_s      = i_req_s && (!d_req_s || starve_hit_s);
      d_sel_s      = d_req_s && !i_sel_s;
   end

   // Request mux and per-cache response steering; Icache requests are always DOUBLE loads.
   always_comb begin
      cache2mem_command   = BUS_NONE;
      cache2mem_size      = DOUBLE;
      cache2mem_addr      = {`XLEN{1'b0}};
      cache2mem_data      = {(2*`XLEN){1'b0}};
      mem2Dcache_response = 4'd0;
      mem2Icache_response = 4'd0;
      if (i_sel_s) begin
         cache2mem_command   = Icache2mem_command;
         cache2mem_size      = DOUBLE;
         cache2mem_addr      = Icache2mem_addr;
         cache2mem_data      = {(2*`XLEN){1'b0}};
         mem2Icache_response = mem2cache_response;
      end else if (d_sel_s) begin
         cache2mem_command   = Dcache2mem_command;
         cache2mem_size      = Dcache2mem_size;
         cache2mem_addr      = Dcache2mem_addr;
         cache2mem_data      = Dcache2mem_data;
         mem2Dcache_response = mem2cache_response;
      end else begin
         cache2mem_command   = BUS_NONE;
         cache2mem_size      = DOUBLE;
      end
   end

   // Return routing uses the table as it stands this cycle, so a same-cycle reallocation
   // of the returning tag still delivers to the previous owner.
   always_comb begin
      ret_hit_s   = 1'b0;
      ret_owner_s = 1'b0;
      if (tag_in_range(mem2cache_tag)) begin
         ret_hit_s   = tag_valid_r[mem2cache_tag];
         ret_owner_s = tag_owner_r[mem2cache_tag];
      end else begin
         ret_hit_s   = 1'b0;
         ret_owner_s = 1'b0;
      end
      alloc_s = (cache2mem_command == BUS_LOAD) && tag_in_range(mem2cache_response);
   end

   // Return-side outputs: data is broadcast, the valid pulse and tag go only to the owner.
   always_comb begin
      mem2Dcache_data       = mem2cache_data;
      mem2Icache_data       = mem2cache_data;
      mem2Dcache_data_valid = ret_hit_s && !ret_owner_s;
      mem2Icache_data_valid = ret_hit_s && ret_owner_s;
      mem2Dcache_tag        = (ret_hit_s && !ret_owner_s) ? mem2cache_tag : 4'd0;
      mem2Icache_tag        = (ret_hit_s && ret_owner_s) ? mem2cache_tag : 4'd0;
   end

   // Starvation counter: counts consecutive lost cycles while the Icache is requesting.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end else if (i_req_s && d_sel_s) begin
         if (starve_cnt_r != STARVE_MAX) begin
            starve_cnt_r <= starve_cnt_r + CNT_W'(1);
         end else begin
            starve_cnt_r <= starve_cnt_r;
         end
      end else begin
         starve_cnt_r <= {CNT_W{1'b0}};
      end
   end

   // Owner table: the allocation write follows the release so it wins on a shared tag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tag_valid_r <= {NUM_TAGS{1'b0}};
         tag_owner_r <= {NUM_TAGS{1'b0}};
      end else begin
         if (ret_hit_s) begin
            tag_valid_r[mem2cache_tag] <= 1'b0;
         end
         if (alloc_s) begin
            tag_valid_r[mem2cache_response] <= 1'b1;
            tag_owner_r[mem2cache_response] <= i_sel_s;
         end
      end
   end

`ifdef MEM_ARB_STATS_EN
   logic realloc_clash_s;

   // An allocation onto a live tag is an error unless that tag is returning this cycle.
   always_comb begin
      realloc_clash_s = alloc_s && tag_valid_r[mem2cache_response] &&
                        !(ret_hit_s && (mem2cache_tag == mem2cache_response));
   end

   // Statistics counters and sticky tag error flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         d_grant_cnt <= 32'd0;
         i_grant_cnt <= 32'd0;
         drop_cnt    <= 32'd0;
         tag_error   <= 1'b0;
      end else begin
         if (d_sel_s && (mem2cache_response != 4'd0)) begin
            d_grant_cnt <= d_grant_cnt + 32'd1;
         end
         if (i_sel_s && (mem2cache_response != 4'd0)) begin
            i_grant_cnt <= i_grant_cnt + 32'd1;
         end
         if ((mem2cache_tag != 4'd0) && !ret_hit_s) begin
            drop_cnt <= drop_cnt + 32'd1;
         end
         if (realloc_clash_s) begin
            tag_error <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter: a reference model predicts each cycle's outputs,
// a negedge monitor compares them.
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_req_arbiter;
   import mem_req_arbiter_pkg::*;

   localparam int XLEN         = `XLEN;
   localparam int STARVE_LIMIT = 4;

   logic               clock;
   logic               reset;
   bus_command_t       Dcache2mem_command;
   mem_size_t          Dcache2mem_size;
   logic [XLEN-1:0]    Dcache2mem_addr;
   logic [2*XLEN-1:0]  Dcache2mem_data;
   bus_command_t       Icache2mem_command;
   logic [XLEN-1:0]    Icache2mem_addr;
   logic [3:0]         mem2cache_response;
   logic [63:0]        mem2cache_data;
   logic [3:0]         mem2cache_tag;
   bus_command_t       cache2mem_command;
   mem_size_t          cache2mem_size;
   logic [XLEN-1:0]    cache2mem_addr;
   logic [2*XLEN-1:0]  cache2mem_data;
   logic [3:0]         mem2Dcache_response;
   logic [3:0]         mem2Icache_response;
   logic [63:0]        mem2Dcache_data;
   logic [63:0]        mem2Icache_data;
   logic [3:0]         mem2Dcache_tag;
   logic [3:0]         mem2Icache_tag;
   logic               mem2Dcache_data_valid;
   logic               mem2Icache_data_valid;
`ifdef MEM_ARB_STATS_EN
   logic [31:0]        d_grant_cnt;
   logic [31:0]        i_grant_cnt;
   logic [31:0]        drop_cnt;
   logic               tag_error;
`endif

   mem_req_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .NUM_TAGS(16)) dut (
      .clock(clock), .reset(reset),
      .Dcache2mem_command(Dcache2mem_command), .Dcache2mem_size(Dcache2mem_size),
      .Dcache2mem_addr(Dcache2mem_addr), .Dcache2mem_data(Dcache2mem_data),
      .Icache2mem_command(Icache2mem_command), .Icache2mem_addr(Icache2mem_addr),
      .mem2cache_response(mem2cache_response), .mem2cache_data(mem2cache_data),
      .mem2cache_tag(mem2cache_tag),
      .cache2mem_command(cache2mem_command), .cache2mem_size(cache2mem_size),
      .cache2mem_addr(cache2mem_addr), .cache2mem_data(cache2mem_data),
      .mem2Dcache_response(mem2Dcache_response), .mem2Icache_response(mem2Icache_response),
      .mem2Dcache_data(mem2Dcache_data), .mem2Icache_data(mem2Icache_data),
      .mem2Dcache_tag(mem2Dcache_tag), .mem2Icache_tag(mem2Icache_tag),
      .mem2Dcache_data_valid(mem2Dcache_data_valid),
      .mem2Icache_data_valid(mem2Icache_data_valid)
`ifdef MEM_ARB_STATS_EN
      ,
      .d_grant_cnt(d_grant_cnt), .i_grant_cnt(i_grant_cnt),
      .drop_cnt(drop_cnt), .tag_error(tag_error)
`endif
   );

   typedef struct {
      bus_command_t       cmd;
      mem_size_t          size;
      logic [XLEN-1:0]    addr;
      logic [2*XLEN-1:0]  data;
      logic [3:0]         d_resp;
      logic [3:0]         i_resp;
      logic [3:0]         d_tag;
      logic [3:0]         i_tag;
      logic               d_v;
      logic               i_v;
      logic [63:0]        rdata;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: tag -> owner (0 = D, 1 = I); presence means outstanding.
   bit   owner_m[int];
   int   lost_m = 0;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares the DUT outputs of each stimulated cycle away from the clock edge.
   always @(negedge clock) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("cmd",      cache2mem_command,     e.cmd);
         chk("size",     cache2mem_size,        e.size);
         chk("addr",     cache2mem_addr,        e.addr);
         chk("data",     cache2mem_data,        e.data);
         chk("d_resp",   mem2Dcache_response,   e.d_resp);
         chk("i_resp",   mem2Icache_response,   e.i_resp);
         chk("d_tag",    mem2Dcache_tag,        e.d_tag);
         chk("i_tag",    mem2Icache_tag,        e.i_tag);
         chk("d_valid",  mem2Dcache_data_valid, e.d_v);
         chk("i_valid",  mem2Icache_data_valid, e.i_v);
         chk("d_rdata",  mem2Dcache_data,       e.rdata);
         chk("i_rdata",  mem2Icache_data,       e.rdata);
      end
   end

   // Drive one cycle of inputs, predict the outputs, then advance the model past the next edge.
   task automatic step(input bus_command_t dc, input mem_size_t ds, input logic [XLEN-1:0] da,
                       input logic [2*XLEN-1:0] dd, input bus_command_t ic,
                       input logic [XLEN-1:0] ia, input logic [3:0] resp,
                       input logic [3:0] rtag, input logic [63:0] rdata);
      exp_t e;
      bit   d_req, i_req, i_win, routed;
      Dcache2mem_command = dc;
      Dcache2mem_size    = ds;
      Dcache2mem_addr    = da;
      Dcache2mem_data    = dd;
      Icache2mem_command = ic;
      Icache2mem_addr    = ia;
      mem2cache_response = resp;
      mem2cache_tag      = rtag;
      mem2cache_data     = rdata;

      d_req = (dc != BUS_NONE);
      i_req = (ic != BUS_NONE);
      i_win = i_req && (!d_req || (STARVE_LIMIT != 0 && lost_m == STARVE_LIMIT));

      e.cmd = BUS_NONE; e.size = DOUBLE; e.addr = '0; e.data = '0;
      e.d_resp = 4'd0; e.i_resp = 4'd0;
      if (i_win) begin
         e.cmd = ic; e.addr = ia; e.i_resp = resp;
      end else if (d_req) begin
         e.cmd = dc; e.size = ds; e.addr = da; e.data = dd; e.d_resp = resp;
      end

      routed = (rtag != 4'd0) && owner_m.exists(int'(rtag));
      e.d_v = routed && !owner_m[int'(rtag)];
      e.i_v = routed && owner_m[int'(rtag)];
      e.d_tag = e.d_v ? rtag : 4'd0;
      e.i_tag = e.i_v ? rtag : 4'd0;
      e.rdata = rdata;
      exp_q.push_back(e);

      if (routed) owner_m.delete(int'(rtag));
      if (e.cmd == BUS_LOAD && resp != 4'd0) owner_m[int'(resp)] = i_win;
      if (i_req && !i_win) lost_m = (lost_m < STARVE_LIMIT) ? lost_m + 1 : lost_m;
      else lost_m = 0;
   endtask

   task automatic idle_step(input logic [3:0] rtag, input logic [63:0] rdata);
      step(BUS_NONE, WORD, '0, '0, BUS_NONE, '0, 4'd0, rtag, rdata);
   endtask

   task automatic next();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      #1;
      idle_step(4'd0, 64'd0);                      // reset state
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Icache-only load accepted with tag 3, data returns next cycle.
      next(); step(BUS_NONE, WORD, '0, '0, BUS_LOAD, 32'h100, 4'd3, 4'd0, 64'd0);
      next(); idle_step(4'd3, 64'hDEAD);

      // Both requesting continuously: D x4, I, D x4, I.
      next(); idle_step(4'd0, 64'd0);
      for (int c = 0; c < 10; c++) begin
         next(); step(BUS_LOAD, WORD, 32'h200, 64'h1111, BUS_LOAD, 32'h100, 4'd0, 4'd0, 64'd0);
      end
      next(); idle_step(4'd0, 64'd0);

      // Stores never allocate.
      next(); step(BUS_STORE, HALF, 32'h300, 64'hABCD, BUS_NONE, '0, 4'd5, 4'd0, 64'd0);
      next(); idle_step(4'd0, 64'd0);
      next(); idle_step(4'd5, 64'h55);

      // Out-of-order returns to two owners.
      next(); step(BUS_LOAD, BYTE, 32'h400, '0, BUS_NONE, '0, 4'd1, 4'd0, 64'd0);
      next(); step(BUS_NONE, WORD, '0, '0, BUS_LOAD, 32'h500, 4'd2, 4'd0, 64'd0);
      next(); idle_step(4'd2, 64'h22);
      next(); idle_step(4'd1, 64'h11);

      // Same-cycle return and reallocation of tag 4.
      next(); step(BUS_LOAD, WORD, 32'h600, '0, BUS_NONE, '0, 4'd4, 4'd0, 64'd0);
      next(); step(BUS_NONE, WORD, '0, '0, BUS_LOAD, 32'h700, 4'd4, 4'd4, 64'h44);
      next(); idle_step(4'd4, 64'h45);

      // Outstanding Icache load on tag 7, starvation built up, then reset mid-cycle.
      next(); step(BUS_NONE, WORD, '0, '0, BUS_LOAD, 32'h800, 4'd7, 4'd0, 64'd0);
      for (int c = 0; c < 2; c++) begin
         next(); step(BUS_LOAD, WORD, 32'h900, '0, BUS_LOAD, 32'h800, 4'd0, 4'd0, 64'd0);
      end
      @(posedge clock);
      #1;
      #1;
      reset = 1'b1;
      owner_m.delete();
      lost_m = 0;
      idle_step(4'd7, 64'h77);
      next();
      reset = 1'b0;
      idle_step(4'd7, 64'h78);
      for (int c = 0; c < 5; c++) begin
         next(); step(BUS_LOAD, WORD, 32'h900, '0, BUS_LOAD, 32'h800, 4'd0, 4'd0, 64'd0);
      end

      // Randomized traffic.
      for (int c = 0; c < 400; c++) begin
         int r;
         bus_command_t dc, ic;
         r  = int'($urandom_range(0, 3));
         dc = (r == 0) ? BUS_LOAD : ((r == 1) ? BUS_STORE : BUS_NONE);
         ic = ($urandom_range(0, 1) == 1) ? BUS_LOAD : BUS_NONE;
         next();
         step(dc, mem_size_t'($urandom_range(0, 3)), $urandom, {$urandom, $urandom}, ic, $urandom,
              ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
              ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
              {$urandom, $urandom});
      end

      next();
      idle_step(4'd0, 64'd0);
      for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clock);
      #1;
      chk("drain", 128'(exp_q.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
